// File: rtl/kpyd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kpyd_pkg
// Purpose  : Shared types, key map and helpers for the 4x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package kpyd_pkg;

  // Column-scan controller states.
  typedef enum logic [0:0] {
    DRIVE = 1'b0,
    EVAL  = 1'b1
  } kpyd_state_e;

  // Snapshot bit index is row*4 + col; entry is the hex code printed on that key.
  localparam logic [3:0] key_map_lp [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Result of a single-bit test on a 16-bit matrix snapshot.
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } onehot16_t;

  // valid=1 when exactly one bit is set; idx is then the position of that bit.
  function automatic onehot16_t onehot16(input logic [15:0] snapshot);
    onehot16_t  res;
    logic [4:0] ones;
    res.valid = 1'b0;
    res.idx   = 4'h0;
    ones      = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        ones    = ones + 5'd1;
        res.idx = 4'(i);
      end
    end
    res.valid = (ones == 5'd1);
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kpyd_debounce.sv
`default_nettype none
// ============================================================================
// Module   : kpyd_debounce
// Purpose  : Accepts a new 16-bit key matrix state once it has been seen on
//            debounce_scans_p consecutive identical full scans.
// Revision : 1.0 - initial release
// ============================================================================
module kpyd_debounce #(
  parameter int debounce_scans_p = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        eval_i,
  input  logic [15:0] snap_i,
  output logic [15:0] deb_o,
  output logic        deb_update_o
);

  localparam int                 c_cnt_w   = $clog2(debounce_scans_p + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(debounce_scans_p);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  logic [15:0]        r_last;
  logic [15:0]        r_deb;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_next;

  // Stability count for this scan; deb_update_o fires in the EVAL cycle that accepts a new state.
  always_comb begin
    w_cnt_next = c_cnt_one;
    if (snap_i == r_last) begin
      w_cnt_next = (r_cnt == c_cnt_max) ? c_cnt_max : r_cnt + c_cnt_one;
    end
    deb_update_o = eval_i && (w_cnt_next == c_cnt_max) && (snap_i != r_deb);
  end

  // Once per scan: remember the snapshot, update the count and the accepted state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_last <= '0;
      r_cnt  <= '0;
      r_deb  <= '0;
    end else if (eval_i) begin
      r_last <= snap_i;
      r_cnt  <= w_cnt_next;
      if (deb_update_o) begin
        r_deb <= snap_i;
      end
    end
  end

  assign deb_o = r_deb;

endmodule
`default_nettype wire

// File: rtl/kpyd_scanner.sv
`default_nettype none
// ============================================================================
// Module   : kpyd_scanner
// Purpose  : 4x4 Pmod keypad scan controller. Walks the columns, samples the
//            synchronized rows, debounces full snapshots and hands one hex key
//            code per new single-key press to a valid/ready consumer.
// Revision : 1.0 - initial release
// ============================================================================
module kpyd_scanner
  import kpyd_pkg::*;
#(
  parameter int settle_cycles_p  = 1200,
  parameter int debounce_scans_p = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] row_async_i,
  output logic [3:0] col_o,
  output logic [3:0] key_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       pressed_o,
  output logic       overrun_o
);

  localparam int                    c_settle_w    = $clog2(settle_cycles_p);
  localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(settle_cycles_p - 1);
  localparam logic [c_settle_w-1:0] c_settle_one  = c_settle_w'(1);

  kpyd_state_e           r_state;
  kpyd_state_e           w_state_next;
  logic                  r_scan_active;
  logic [c_settle_w-1:0] r_cnt;
  logic [c_settle_w-1:0] w_cnt_next;
  logic [1:0]            r_col_idx;
  logic [1:0]            w_col_idx_next;
  logic                  w_sample;
  logic                  w_eval;
  logic [3:0]            r_col;
  logic [3:0]            r_row_meta;
  logic [3:0]            r_row_sync;
  logic [3:0]            w_rows;
  logic [15:0]           r_snap;
  logic [15:0]           w_snap_next;
  logic [15:0]           w_deb;
  logic                  w_deb_update;
  onehot16_t             w_hit;
  logic                  w_event;
  logic [3:0]            r_key;
  logic                  r_valid;
  logic                  r_pressed;
  logic                  r_overrun;

  // Two-flop synchronizer; idle level is all rows high (no key).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= row_async_i;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_rows = ~r_row_sync;

  // Settle counter and column stepping; EVAL overlaps the first column-0 cycle.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_col_idx_next = r_col_idx;
    w_sample       = 1'b0;
    if (r_scan_active) begin
      if (r_state == EVAL) begin
        w_state_next = DRIVE;
      end
      if (r_cnt == c_settle_last) begin
        w_sample       = 1'b1;
        w_cnt_next     = '0;
        w_col_idx_next = r_col_idx + 2'd1;
        if (r_col_idx == 2'd3) begin
          w_state_next = EVAL;
        end
      end else begin
        w_cnt_next = r_cnt + c_settle_one;
      end
    end
  end

  assign w_eval = (r_state == EVAL);

  // State register; scanning begins with column 0 on the first cycle out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= DRIVE;
      r_scan_active <= 1'b0;
      r_cnt         <= '0;
      r_col_idx     <= 2'd0;
      r_col         <= 4'hF;
    end else begin
      r_state       <= w_state_next;
      r_scan_active <= 1'b1;
      r_cnt         <= w_cnt_next;
      r_col_idx     <= w_col_idx_next;
      r_col         <= ~(4'b0001 << w_col_idx_next);
    end
  end

  // Place the four row samples of the driven column into the snapshot.
  always_comb begin
    w_snap_next = r_snap;
    if (w_sample) begin
      w_snap_next[{2'd0, r_col_idx}] = w_rows[0];
      w_snap_next[{2'd1, r_col_idx}] = w_rows[1];
      w_snap_next[{2'd2, r_col_idx}] = w_rows[2];
      w_snap_next[{2'd3, r_col_idx}] = w_rows[3];
    end
  end

  // Snapshot register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_snap <= '0;
    end else begin
      r_snap <= w_snap_next;
    end
  end

  kpyd_debounce #(
    .debounce_scans_p (debounce_scans_p)
  ) u_debounce (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .eval_i       (w_eval),
    .snap_i       (r_snap),
    .deb_o        (w_deb),
    .deb_update_o (w_deb_update)
  );

  // A new accepted state with one key down, and that key newly down, is an event.
  assign w_hit   = onehot16(r_snap);
  assign w_event = w_deb_update && w_hit.valid && !w_deb[w_hit.idx];

  // Output handshake: load when empty, otherwise drop and flag overrun (no bypass).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_key     <= 4'h0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_event && r_valid;
      if (w_event && !r_valid) begin
        r_key   <= key_map_lp[w_hit.idx];
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Debounced "any key down" flag, one cycle behind the accepted state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pressed <= 1'b0;
    end else begin
      r_pressed <= |w_deb;
    end
  end

  assign col_o     = r_col;
  assign key_o     = r_key;
  assign valid_o   = r_valid;
  assign pressed_o = r_pressed;
  assign overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_kpyd_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_kpyd_scanner
// Purpose  : Directed bench for kpyd_scanner with a keypad model and an
//            event scoreboard (settle 4 cycles, debounce 2 scans).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kpyd_scanner;

  localparam int c_settle = 4;
  localparam int c_deb    = 2;

  // Key positions in the bench keypad model (row*4 + col).
  localparam logic [15:0] c_k1 = 16'h0001; // r0 c0
  localparam logic [15:0] c_k6 = 16'h0040; // r1 c2
  localparam logic [15:0] c_k9 = 16'h0400; // r2 c2
  localparam logic [15:0] c_kd = 16'h8000; // r3 c3

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        ready_i = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  col_o;
  logic [3:0]  key_o;
  logic        valid_o;
  logic        pressed_o;
  logic        overrun_o;
  logic [15:0] keys = 16'h0000;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_key_q [$];
  logic [3:0] exp_ovr_q [$];
  logic       prev_valid = 1'b0;
  logic       prev_ovr   = 1'b0;

  always #5 clk = ~clk;

  kpyd_scanner #(
    .settle_cycles_p  (c_settle),
    .debounce_scans_p (c_deb)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .row_async_i (rows),
    .col_o       (col_o),
    .key_o       (key_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .pressed_o   (pressed_o),
    .overrun_o   (overrun_o)
  );

  // Physical keypad: a held key pulls its row low while its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col_o[c] && keys[r*4+c]) rows[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int i;
    i = 0;
    while (valid_o !== 1'b1 && i < budget) begin
      tick(1);
      i++;
    end
    n_vec++;
    if (valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s: valid_o=%b after %0d cycles, required 1", name, valid_o, budget);
    end
  endtask

  task automatic wait_overrun(input int budget, input string name);
    int i;
    i = 0;
    while (overrun_o !== 1'b1 && i < budget) begin
      tick(1);
      i++;
    end
    n_vec++;
    if (overrun_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s: overrun_o=%b after %0d cycles, required 1", name, overrun_o, budget);
    end
  endtask

  task automatic consume(input string name);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    check(name, {15'h0, valid_o}, 16'h0000);
  endtask

  // Scoreboard monitor: each valid_o rise and each overrun pulse is matched to a queued expectation.
  always @(negedge clk) begin
    if (valid_o === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_key_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got key %h, required no event", key_o);
      end else begin
        check("key_event", {12'h0, key_o}, {12'h0, exp_key_q.pop_front()});
      end
    end
    if (overrun_o === 1'b1) begin
      if (prev_ovr === 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL overrun_width: got overrun_o high 2+ cycles, required 1 cycle");
      end else if (exp_ovr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_overrun: got overrun_o=1, required 0");
      end else begin
        check("overrun_key", {12'h0, key_o}, {12'h0, exp_ovr_q.pop_front()});
      end
    end
    prev_valid = valid_o;
    prev_ovr   = overrun_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;

    // 1 Reset: outputs idle while held, then column walk.
    repeat (3) begin
      tick(1);
      check("reset_outs", {5'h0, col_o, key_o, valid_o, pressed_o, overrun_o},
            {5'h0, 4'hF, 4'h0, 3'b000});
    end
    keys    = c_k6;
    reset_i = 1'b0;
    exp_key_q.push_back(4'h6);
    tick(1);
    check("first_col", {12'h0, col_o}, 16'h000E);
    for (int k = 1; k < 16; k++) begin
      tick(1);
      exp_col = ~(4'b0001 << (k / 4));
      check("col_walk", {12'h0, col_o}, {12'h0, exp_col});
    end

    // 2 Single press '6' held from scan 0: reported one cycle after the 2nd EVAL.
    tick(17);
    check("pre_event", {14'h0, valid_o, pressed_o}, 16'h0000);
    tick(1);
    check("event_6", {11'h0, valid_o, key_o, pressed_o}, {11'h0, 1'b1, 4'h6, 1'b0});
    tick(1);
    check("pressed_6", {15'h0, pressed_o}, 16'h0001);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("hold_6", {11'h0, valid_o, key_o}, {11'h0, 1'b1, 4'h6});
    end
    consume("accept_6");
    tick(48);
    check("no_refire", {15'h0, valid_o}, 16'h0000);

    // 3 Bounce: alternating scans never accepted, then a steady press is.
    keys = 16'h0000;
    tick(64);
    check("release_6", {15'h0, pressed_o}, 16'h0000);
    for (int s = 0; s < 10; s++) begin
      keys = (s % 2 == 0) ? c_k6 : 16'h0000;
      tick(16);
      check("bounce", {14'h0, valid_o, pressed_o}, 16'h0000);
    end
    keys = c_k6;
    exp_key_q.push_back(4'h6);
    wait_valid(80, "bounce_settled");
    tick(1);
    check("pressed_after_bounce", {15'h0, pressed_o}, 16'h0001);
    consume("accept_bounce");

    // 4 Multi-key: no event for two keys, nor for dropping back to an already-set key.
    keys = c_k1 | c_k9;
    tick(64);
    check("multi", {14'h0, valid_o, pressed_o}, 16'h0001);
    keys = c_k1;
    tick(64);
    check("release_9", {14'h0, valid_o, pressed_o}, 16'h0001);
    keys = 16'h0000;
    tick(64);
    check("release_all", {14'h0, valid_o, pressed_o}, 16'h0000);
    keys = c_k1;
    exp_key_q.push_back(4'h1);
    wait_valid(80, "event_1");
    consume("accept_1");

    // 5 Overrun: 'D' arrives while '6' is still unconsumed.
    keys = 16'h0000;
    tick(64);
    keys = c_k6;
    exp_key_q.push_back(4'h6);
    wait_valid(80, "event_6b");
    keys = 16'h0000;
    tick(64);
    check("held_6b", {11'h0, valid_o, key_o}, {11'h0, 1'b1, 4'h6});
    keys = c_kd;
    exp_ovr_q.push_back(4'h6);
    wait_overrun(80, "overrun_d");
    tick(1);
    check("after_overrun", {10'h0, valid_o, key_o, overrun_o}, {10'h0, 1'b1, 4'h6, 1'b0});

    // 6 Reset during column 2 with valid_o high; held 'D' re-reports after 2 scans.
    begin
      int i;
      i = 0;
      while (col_o !== 4'b1011 && i < 20) begin
        tick(1);
        i++;
      end
      check("reach_col2", {12'h0, col_o}, 16'h000B);
    end
    reset_i = 1'b1;
    tick(1);
    check("midscan_reset", {5'h0, col_o, key_o, valid_o, pressed_o, overrun_o},
          {5'h0, 4'hF, 4'h0, 3'b000});
    reset_i = 1'b0;
    exp_key_q.push_back(4'hD);
    tick(1);
    check("restart_col0", {12'h0, col_o}, 16'h000E);
    tick(32);
    check("pre_event_d", {15'h0, valid_o}, 16'h0000);
    tick(1);
    check("event_d", {11'h0, valid_o, key_o}, {11'h0, 1'b1, 4'hD});
    consume("accept_d");

    keys = 16'h0000;
    tick(4);
    check("pending_events", 16'(exp_key_q.size() + exp_ovr_q.size()), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
